// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer.
//   state_t   : sequencer FSM states (IDLE, SETTLE, RESP)
//   OP_*      : ALU opcode encodings the sequencer cares about
//   ERR_*     : bit positions inside the 2-bit ALU error word
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] OP_CLR = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;

    localparam int ERR_OVF = 0;
    localparam int ERR_DZE = 1;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of every signal between the sequencer and its environment.
//   Command channel : cmd_valid, cmd_ready, cmd_op, cmd_a, cmd_b, cmd_acc
//   ALU side        : in1, in2, op (to ALU), out, err (from ALU)
//   Response channel: res_valid, res_ready, res_data, res_err
//   Status          : acc, err_sticky, opcount
// master = environment (command source, ALU, response sink)
// slave  = alu_sequencer
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_acc;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  op;
    logic [31:0] out;
    logic [1:0]  err;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_err;
    logic [31:0] acc;
    logic [1:0]  err_sticky;
    logic [15:0] opcount;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, out, err, res_ready,
        input  cmd_ready, in1, in2, op, res_valid, res_data, res_err,
               acc, err_sticky, opcount
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, out, err, res_ready,
        output cmd_ready, in1, in2, op, res_valid, res_data, res_err,
               acc, err_sticky, opcount
    );
endinterface

// File: rtl/alu_sequencer_settle_timer.sv
// settle_timer: 4-bit load/decrement counter used to time the ALU settle window.
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : load load_val_i into the counter
//   load_val_i  : settle length (1..15)
//   en_i        : count down while asserted
//   done_o      : counter equals 1 (last settle cycle)
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);
    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && !done_o) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'd1);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front-end for a combinational ALU. Accepts a
// command, holds the ALU inputs for SETTLE_CYCLES, captures result/error into
// a response register and accumulator, then hands the response back.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_sequencer_if.slave (command, ALU, response, status)
// Parameter SETTLE_CYCLES (1..15): cycles the ALU inputs settle before capture.
// Optional macro ALU_SEQ_ACC_FEEDBACK_EN: when defined, cmd_acc=1 selects
// acc[15:0] as operand A; otherwise cmd_acc is ignored.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    alu_sequencer_if.slave bus
);
    state_t      state_q;
    logic        cmd_ready_q;
    logic [15:0] in1_q, in2_q;
    logic [3:0]  op_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic [1:0]  res_err_q;
    logic [31:0] acc_q;
    logic [1:0]  err_sticky_q;
    logic [15:0] opcount_q;

    logic        accept;
    logic        settle_done;
    logic [15:0] in1_d;

    assign accept = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;

`ifdef ALU_SEQ_ACC_FEEDBACK_EN
    assign in1_d = bus.cmd_acc ? acc_q[15:0] : bus.cmd_a;
`else
    assign in1_d = bus.cmd_a;
    logic unused_cmd_acc;
    assign unused_cmd_acc = bus.cmd_acc;
`endif

    settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (4'(SETTLE_CYCLES)),
        .en_i       (state_q == ST_SETTLE),
        .done_o     (settle_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            in1_q        <= '0;
            in2_q        <= '0;
            op_q         <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= '0;
            acc_q        <= '0;
            err_sticky_q <= '0;
            opcount_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready rises one cycle after reset release
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        in1_q       <= in1_d;
                        in2_q       <= bus.cmd_b;
                        op_q        <= bus.cmd_op;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        res_data_q  <= bus.out;
                        res_err_q   <= bus.err;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                        // CLR wins over the sticky OR; errored results leave acc alone
                        if (op_q == OP_CLR) begin
                            acc_q        <= '0;
                            err_sticky_q <= '0;
                        end else begin
                            err_sticky_q <= err_sticky_q | bus.err;
                            if (bus.err == 2'b00) begin
                                acc_q <= bus.out;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        opcount_q   <= opcount_q + 16'd1;
                        // ready again immediately so back-to-back period is SETTLE_CYCLES+2
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.in1        = in1_q;
    assign bus.in2        = in2_q;
    assign bus.op         = op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_err    = res_err_q;
    assign bus.acc        = acc_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.opcount    = opcount_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU beside it.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_sequencer_if bus ();

    alu_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        bus.out = 32'd0;
        bus.err = 2'b00;
        case (bus.op)
            4'b0010: begin
                bus.out = {16'd0, bus.in1} + {16'd0, bus.in2};
                bus.err[0] = bus.out[16];
            end
            4'b0011: begin
                bus.out = {16'd0, bus.in1} - {16'd0, bus.in2};
                bus.err[0] = (bus.in1 < bus.in2);
            end
            4'b0100: bus.out = {16'd0, bus.in1} * {16'd0, bus.in2};
            4'b0101: begin
                if (bus.in2 == 16'd0) bus.err = 2'b10;
                else bus.out = {16'd0, bus.in1 / bus.in2};
            end
            4'b0110: begin
                if (bus.in2 == 16'd0) bus.err = 2'b10;
                else bus.out = {16'd0, bus.in1 % bus.in2};
            end
            default: begin
                bus.out = 32'd0;
                bus.err = 2'b00;
            end
        endcase
    end

    // Drives one command and waits (bounded) for res_valid; lat counts edges after accept.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic sel_acc, output int lat, output bit ok);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_acc   = sel_acc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = bus.res_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%0d exp=0", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%0d exp=0", bus.res_valid); end
        checks++; if (bus.acc !== 32'd0) begin failures++; $display("FAIL rst_acc got=%0h exp=0", bus.acc); end
        checks++; if (bus.opcount !== 16'd0) begin failures++; $display("FAIL rst_opcount got=%0d exp=0", bus.opcount); end
        checks++; if (bus.err_sticky !== 2'b00) begin failures++; $display("FAIL rst_sticky got=%0b exp=0", bus.err_sticky); end
        checks++; if (bus.in1 !== 16'd0 || bus.op !== 4'd0) begin failures++; $display("FAIL rst_alu_in got=%0h/%0h exp=0/0", bus.in1, bus.op); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rel_cmd_ready got=%0d exp=1", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rel_res_valid got=%0d exp=0", bus.res_valid); end
    endtask

    task automatic test_add();
        int lat; bit ok;
        bus.res_ready = 1'b1;
        issue(4'b0010, 16'd11, 16'd51, 1'b0, lat, ok);
        checks++; if (!ok || lat != 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++; if (bus.res_data !== 32'd62) begin failures++; $display("FAIL add_data got=%0d exp=62", bus.res_data); end
        checks++; if (bus.res_err !== 2'b00) begin failures++; $display("FAIL add_err got=%0b exp=00", bus.res_err); end
        checks++; if (bus.acc !== 32'd62) begin failures++; $display("FAIL add_acc got=%0d exp=62", bus.acc); end
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL add_busy got=%0d exp=0", bus.cmd_ready); end
        @(posedge clk); #1;
        checks++; if (bus.opcount !== 16'd1) begin failures++; $display("FAIL add_opcount got=%0d exp=1", bus.opcount); end
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL add_res_drop got=%0d exp=0", bus.res_valid); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL add_ready_back got=%0d exp=1", bus.cmd_ready); end
    endtask

    task automatic test_sub();
        int lat; bit ok;
        issue(4'b0011, 16'd11, 16'd51, 1'b0, lat, ok);
        checks++; if (!ok || lat != 2) begin failures++; $display("FAIL sub_latency got=%0d exp=2", lat); end
        checks++; if (bus.res_data !== 32'hFFFFFFD8) begin failures++; $display("FAIL sub_data got=%0h exp=ffffffd8", bus.res_data); end
        checks++; if (bus.res_err !== 2'b01) begin failures++; $display("FAIL sub_err got=%0b exp=01", bus.res_err); end
        checks++; if (bus.acc !== 32'd62) begin failures++; $display("FAIL sub_acc got=%0d exp=62", bus.acc); end
        checks++; if (bus.err_sticky !== 2'b01) begin failures++; $display("FAIL sub_sticky got=%0b exp=01", bus.err_sticky); end
        @(posedge clk); #1;
        checks++; if (bus.opcount !== 16'd2) begin failures++; $display("FAIL sub_opcount got=%0d exp=2", bus.opcount); end
    endtask

    task automatic test_mul_div();
        int lat; bit ok;
        issue(4'b0100, 16'd62091, 16'd47411, 1'b0, lat, ok);
        checks++; if (!ok || bus.res_data !== 32'd2943796401) begin failures++; $display("FAIL mul_data got=%0d exp=2943796401", bus.res_data); end
        checks++; if (bus.res_err !== 2'b00) begin failures++; $display("FAIL mul_err got=%0b exp=00", bus.res_err); end
        checks++; if (bus.acc !== 32'd2943796401) begin failures++; $display("FAIL mul_acc got=%0d exp=2943796401", bus.acc); end
        @(posedge clk); #1;
        issue(4'b0101, 16'd11, 16'd0, 1'b0, lat, ok);
        checks++; if (!ok || bus.res_data !== 32'd0) begin failures++; $display("FAIL div_data got=%0d exp=0", bus.res_data); end
        checks++; if (bus.res_err !== 2'b10) begin failures++; $display("FAIL div_err got=%0b exp=10", bus.res_err); end
        checks++; if (bus.err_sticky !== 2'b11) begin failures++; $display("FAIL div_sticky got=%0b exp=11", bus.err_sticky); end
        checks++; if (bus.acc !== 32'd2943796401) begin failures++; $display("FAIL div_acc got=%0d exp=2943796401", bus.acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_feedback();
        int lat; bit ok;
        logic [31:0] exp_fb;
        issue(4'b0000, 16'd5, 16'd6, 1'b0, lat, ok);
        checks++; if (!ok || bus.acc !== 32'd0) begin failures++; $display("FAIL clr_acc got=%0d exp=0", bus.acc); end
        checks++; if (bus.err_sticky !== 2'b00) begin failures++; $display("FAIL clr_sticky got=%0b exp=00", bus.err_sticky); end
        @(posedge clk); #1;
        issue(4'b1111, 16'd9, 16'd9, 1'b0, lat, ok);
        checks++; if (!ok || bus.res_data !== 32'd0) begin failures++; $display("FAIL undef_op_data got=%0d exp=0", bus.res_data); end
        @(posedge clk); #1;
        issue(4'b0010, 16'd11, 16'd51, 1'b0, lat, ok);
        @(posedge clk); #1;
`ifdef ALU_SEQ_ACC_FEEDBACK_EN
        exp_fb = 32'd70;
`else
        exp_fb = 32'd108;
`endif
        issue(4'b0010, 16'd100, 16'd8, 1'b1, lat, ok);
        checks++; if (!ok || bus.res_data !== exp_fb) begin failures++; $display("FAIL acc_feedback got=%0d exp=%0d", bus.res_data, exp_fb); end
        @(posedge clk); #1;
        checks++; if (bus.opcount !== 16'd8) begin failures++; $display("FAIL opcount_8 got=%0d exp=8", bus.opcount); end
    endtask

    task automatic test_backpressure_reset();
        int lat; bit ok; bit rose;
        bus.res_ready = 1'b0;
        issue(4'b0010, 16'd5, 16'd6, 1'b0, lat, ok);
        checks++; if (!ok || lat != 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'b0010;
        bus.cmd_a     = 16'd7;
        bus.cmd_b     = 16'd8;
        bus.cmd_acc   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 32'd11) begin
                failures++; $display("FAIL bp_hold%0d got=rdy%0d vld%0d data%0d exp=rdy0 vld1 data11", i, bus.cmd_ready, bus.res_valid, bus.res_data);
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.opcount !== 16'd9 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=cnt%0d vld%0d exp=cnt9 vld0", bus.opcount, bus.res_valid); end
        @(posedge clk); #1;
        checks++; if (bus.in1 !== 16'd7 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_next_accept got=in1 %0d rdy%0d exp=in1 7 rdy0", bus.in1, bus.cmd_ready); end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl got=vld%0d rdy%0d exp=vld0 rdy0", bus.res_valid, bus.cmd_ready); end
        checks++; if (bus.acc !== 32'd0 || bus.opcount !== 16'd0 || bus.in1 !== 16'd0 || bus.res_data !== 32'd0) begin
            failures++; $display("FAIL mid_rst_data got=acc%0d cnt%0d in1 %0d data%0d exp=all 0", bus.acc, bus.opcount, bus.in1, bus.res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0) begin failures++; $display("FAIL mid_rst_no_resp got=%0d exp=0", rose); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.opcount !== 16'd0) begin failures++; $display("FAIL post_rst got=rdy%0d cnt%0d exp=rdy1 cnt0", bus.cmd_ready, bus.opcount); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 16'd0;
        bus.cmd_b     = 16'd0;
        bus.cmd_acc   = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul_div();
        test_clr_feedback();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
